usb_pkt_tx: RTL

Synthesizable USB full/low-speed packet transmitter, and the parametrised successor to the behavioural host-side encoder used by the USB test environment. It accepts packet bytes over a valid/ready handshake and drives the bus pins. It frames each packet with SYNC and EOP, applies bit stuffing and NRZI encoding, and produces the differential `dp`/`dn` drive with output enable `doe`. Compared with the earlier encoder it adds a runtime speed mode with per-speed bit-time parameters and byte-streamed packets of unbounded length. It keeps error injection, now as synthesizable per-packet controls: suppressed bit stuffing and corrupted SYNC.

---
 rtl/usb_pkt_tx.sv | 227 ++++++++++++++++++++++
 1 files changed

// File: rtl/usb_pkt_tx.sv
// usb_pkt_tx -- USB full/low-speed packet transmitter.
//
// Takes packet bytes from a byte stream and drives the USB pins. Each packet
// is framed as SYNC, data (LSB first, bit stuffed, NRZI encoded), then EOP
// (two bit times of SE0 and one of J). Speed, stuffing suppression and SYNC
// corruption are captured once per packet when the first byte is accepted.
//
// Handshake: tx_ready is a combinational single-cycle pulse. A byte on
// tx_data/tx_last is consumed on exactly the clock where tx_valid and
// tx_ready are both 1. tx_ready only rises in IDLE (packet start) or on the
// bit boundary that ends the previous byte (its bit 7 or its owed stuff bit).
// At any other time tx_valid is ignored.
//
// Ports:
//   clk, rst           clock; synchronous active-high reset
//   speed              1 = full speed, 0 = low speed (sampled at start)
//   err_bitstuff       suppress bit stuffing for the packet (sampled at start)
//   sync_corrupt       send last SYNC bit as J (sampled at start)
//   tx_data, tx_last   packet byte and end-of-packet flag
//   tx_valid/tx_ready  byte handshake as described above
//   busy               packet in progress, SYNC through EOP
//   underrun           pulse when a byte was needed and none was offered
//   dp, dn, doe        bus drive values and output enable
module usb_pkt_tx #(
  parameter int CLK_PER_BIT_FS = 4,
  parameter int CLK_PER_BIT_LS = 32
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       speed,
  input  logic       err_bitstuff,
  input  logic       sync_corrupt,
  input  logic [7:0] tx_data,
  input  logic       tx_valid,
  input  logic       tx_last,
  output logic       tx_ready,
  output logic       busy,
  output logic       underrun,
  output logic       dp,
  output logic       dn,
  output logic       doe
);

  localparam int TW = (CLK_PER_BIT_LS > 1) ? $clog2(CLK_PER_BIT_LS) : 1;
  localparam logic [TW-1:0] FS_LAST = TW'(CLK_PER_BIT_FS - 1);
  localparam logic [TW-1:0] LS_LAST = TW'(CLK_PER_BIT_LS - 1);

  typedef enum logic [2:0] {IDLE, SYNC, DATA, EOP_SE0, EOP_J} state_t;

  state_t          state_q, state_d;
  logic [TW-1:0]   bit_cnt_q, bit_cnt_d;
  logic [2:0]      bit_idx_q, bit_idx_d;   // SYNC bit, data bit or EOP_SE0 bit
  logic [2:0]      ones_q, ones_d;         // consecutive raw ones sent
  logic [7:0]      shreg_q, shreg_d;       // bit 0 is the data bit on the line
  logic            last_q, last_d;
  logic            spd_q, spd_d;
  logic            no_stuff_q, no_stuff_d;
  logic            sync_bad_q, sync_bad_d;
  logic            lvl_q, lvl_d;           // line level: 1 = J, 0 = K
  logic            se0_q, se0_d;
  logic            stuff_q, stuff_d;       // current slot is a stuffed 0

  logic            bit_end;
  logic            stuff_owed;
  logic            take;
  logic            raw;
  logic [2:0]      ones_inc;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      bit_cnt_q  <= '0;
      bit_idx_q  <= '0;
      ones_q     <= '0;
      shreg_q    <= '0;
      last_q     <= 1'b0;
      spd_q      <= 1'b1;
      no_stuff_q <= 1'b0;
      sync_bad_q <= 1'b0;
      lvl_q      <= 1'b1;
      se0_q      <= 1'b0;
      stuff_q    <= 1'b0;
    end else begin
      state_q    <= state_d;
      bit_cnt_q  <= bit_cnt_d;
      bit_idx_q  <= bit_idx_d;
      ones_q     <= ones_d;
      shreg_q    <= shreg_d;
      last_q     <= last_d;
      spd_q      <= spd_d;
      no_stuff_q <= no_stuff_d;
      sync_bad_q <= sync_bad_d;
      lvl_q      <= lvl_d;
      se0_q      <= se0_d;
      stuff_q    <= stuff_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    bit_cnt_d  = bit_cnt_q;
    bit_idx_d  = bit_idx_q;
    ones_d     = ones_q;
    shreg_d    = shreg_q;
    last_d     = last_q;
    spd_d      = spd_q;
    no_stuff_d = no_stuff_q;
    sync_bad_d = sync_bad_q;
    lvl_d      = lvl_q;
    se0_d      = se0_q;
    stuff_d    = stuff_q;
    tx_ready   = 1'b0;
    underrun   = 1'b0;
    take       = 1'b0;
    raw        = 1'b0;

    bit_end    = (state_q != IDLE) && (bit_cnt_q == (spd_q ? FS_LAST : LS_LAST));
    stuff_owed = !no_stuff_q && (ones_q == 3'd6);
    // Saturate so the count stays in range when stuffing is suppressed.
    ones_inc   = (ones_q == 3'd6) ? 3'd6 : ones_q + 3'd1;

    if (state_q != IDLE) begin
      bit_cnt_d = bit_end ? '0 : bit_cnt_q + 1'b1;
    end

    case (state_q)
      IDLE: begin
        if (tx_valid) begin
          tx_ready   = 1'b1;
          state_d    = SYNC;
          shreg_d    = tx_data;
          last_d     = tx_last;
          spd_d      = speed;
          no_stuff_d = err_bitstuff;
          sync_bad_d = sync_corrupt;
          bit_cnt_d  = '0;
          bit_idx_d  = '0;
          ones_d     = '0;
          se0_d      = 1'b0;
          stuff_d    = 1'b0;
          lvl_d      = 1'b0;   // first SYNC bit is a raw 0: J toggles to K
        end
      end
      SYNC: begin
        if (bit_end) begin
          take = 1'b1;
          if (bit_idx_q == 3'd7) begin
            state_d   = DATA;
            bit_idx_d = '0;
            raw       = shreg_q[0];
          end else begin
            bit_idx_d = bit_idx_q + 3'd1;
            raw       = (bit_idx_q == 3'd6) ? !sync_bad_q : 1'b0;
          end
        end
      end
      DATA: begin
        if (bit_end) begin
          if (stuff_owed) begin
            // Stuffed slot: toggle without consuming a data bit.
            lvl_d   = !lvl_q;
            ones_d  = '0;
            stuff_d = 1'b1;
          end else if (bit_idx_q != 3'd7) begin
            take      = 1'b1;
            raw       = shreg_q[1];
            shreg_d   = {1'b0, shreg_q[7:1]};
            bit_idx_d = bit_idx_q + 3'd1;
          end else if (last_q) begin
            state_d   = EOP_SE0;
            se0_d     = 1'b1;
            bit_idx_d = '0;
          end else if (tx_valid) begin
            tx_ready  = 1'b1;
            take      = 1'b1;
            raw       = tx_data[0];
            shreg_d   = tx_data;
            last_d    = tx_last;
            bit_idx_d = '0;
          end else begin
            underrun  = 1'b1;
            state_d   = EOP_SE0;
            se0_d     = 1'b1;
            bit_idx_d = '0;
          end
        end
      end
      EOP_SE0: begin
        if (bit_end) begin
          if (bit_idx_q == 3'd0) begin
            bit_idx_d = 3'd1;
          end else begin
            state_d = EOP_J;
            se0_d   = 1'b0;
            lvl_d   = 1'b1;
          end
        end
      end
      EOP_J: begin
        if (bit_end) begin
          state_d   = IDLE;
          bit_cnt_d = '0;
        end
      end
      default: state_d = IDLE;
    endcase

    // NRZI: raw 0 toggles the line, raw 1 holds it.
    if (take) begin
      lvl_d   = raw ? lvl_q : !lvl_q;
      ones_d  = raw ? ones_inc : 3'd0;
      stuff_d = 1'b0;
    end

    if (rst) begin
      tx_ready = 1'b0;
      underrun = 1'b0;
    end
  end

  // J is dp=1/dn=0 at full speed and dp=0/dn=1 at low speed.
  assign doe  = (state_q != IDLE);
  assign busy = (state_q != IDLE);
  assign dp   = !se0_q && (lvl_q ~^ spd_q);
  assign dn   = !se0_q && !(lvl_q ~^ spd_q);

endmodule
